// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter.
//   - arb_state_e   : arbiter FSM states
//   - MaxReq        : widest request vector the helper functions handle
//   - onehot_to_idx : binary index of a one-hot vector
//   - rotl / rotr   : rotate the low n bits of a vector by amt positions
package rr_arb_pkg;

  localparam int unsigned MaxReq = 32;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } arb_state_e;

  // Zero input yields 0; for a one-hot input this is the position of the set bit.
  function automatic int unsigned onehot_to_idx(input logic [MaxReq-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic logic [MaxReq-1:0] rotl(input logic [MaxReq-1:0] v,
                                             input int unsigned amt,
                                             input int unsigned n);
    logic [MaxReq-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      r[(i + amt) % n] = v[i];
    end
    return r;
  endfunction

  function automatic logic [MaxReq-1:0] rotr(input logic [MaxReq-1:0] v,
                                             input int unsigned amt,
                                             input int unsigned n);
    logic [MaxReq-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      r[i] = v[(i + amt) % n];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker.
// Finds the first set bit of req scanning upward from ptr, wrapping NUM_REQ-1 -> 0.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  IDX_W    highest-priority position
//   winner out NUM_REQ  one-hot winner (zero when no request)
//   idx    out IDX_W    binary index of winner (0 when no request)
//   any    out 1        at least one request present
// NUM_REQ must not exceed rr_arb_pkg::MaxReq.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] masked;
  logic                 found;

  // The upper copy of req supplies the wrapped-around candidates once the
  // positions below ptr in the lower copy are masked off.
  always_comb begin
    dbl    = {req, req};
    masked = '0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      masked[i] = dbl[i] & (i >= int'(ptr));
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (masked[i] && !found) begin
        found                = 1'b1;
        winner[i % NUM_REQ]  = 1'b1;
      end
    end
  end

  assign any = found;
  assign idx = IDX_W'(onehot_to_idx(MaxReq'(winner)));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and valid/ready handshake.
// A rotating pointer gives the position after the last accepted requester top
// priority; back-to-back grants are issued without a bubble.
// Ports:
//   clk        in  1        clock, rising edge
//   rst        in  1        synchronous active-high reset
//   req        in  NUM_REQ  request vector
//   gnt        out NUM_REQ  registered one-hot grant, zero when gnt_valid=0
//   gnt_idx    out IDX_W    binary index of gnt, zero when gnt_valid=0
//   gnt_valid  out 1        grant presented
//   gnt_ready  in  1        downstream accepts the grant
//   lock       in  1        only with RR_ARB_LOCK_EN: keep the current owner
// Build option: define RR_ARB_LOCK_EN to add the lock port. When lock is high in
// the accept cycle and the owner still requests, it is regranted and the pointer
// does not move.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  input  logic               gnt_ready
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic               lock
`endif
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic               accept;
  logic               lock_hit;
  logic [IDX_W-1:0]   ptr_adv;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  assign accept  = (state_q == StGrant) && gnt_ready;
  assign ptr_adv = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDX_W'(1);

`ifdef RR_ARB_LOCK_EN
  // A locked owner that has dropped its request falls back to normal arbitration.
  assign lock_hit = accept && lock && req[gnt_idx_q];
`else
  assign lock_hit = 1'b0;
`endif

  // In the accept cycle re-arbitration must already see the advanced pointer.
  assign pick_ptr = (state_q == StGrant) ? ptr_adv : ptr_q;

  rr_prio_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .winner(pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gnt_d     = pick_gnt;
          gnt_idx_d = pick_idx;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        // Grant is sticky: only an accept can change it.
        if (accept && !lock_hit) begin
          ptr_d = ptr_adv;
          if (pick_any) begin
            gnt_d     = pick_gnt;
            gnt_idx_d = pick_idx;
          end else begin
            gnt_d     = '0;
            gnt_idx_d = '0;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        gnt_d     = '0;
        gnt_idx_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = (state_q == StGrant);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (NUM_REQ=4). Inputs change 1 time unit after a
// falling edge; outputs are checked at the falling edge. A scoreboard holds the
// grants expected at each handshake, and monitors check one-hot, hold-while-stalled
// and the fairness bound.
module tb_rr_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_valid;
  logic         gnt_ready;
  logic         lock;

  logic [N-1:0] sb_q[$];
  int           n_total = 0;
  int           n_pass  = 0;

  always #5 clk = ~clk;

  rr_arbiter #(
    .NUM_REQ(N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .gnt_ready(gnt_ready)
`ifdef RR_ARB_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic push(input logic [N-1:0] g);
    sb_q.push_back(g);
  endtask

  // Monitors sample 2 units after the falling edge: outputs are those of the
  // last rising edge and inputs are those the next rising edge will see.
  int           wait_cnt[N];
  logic         stall_q   = 1'b0;
  logic [N-1:0] stall_gnt = '0;

  always @(negedge clk) begin
    #2;
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("valid_eq_or", 32'(gnt_valid), 32'(|gnt));
    if (rst) begin
      stall_q = 1'b0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    end else begin
      if (stall_q) check("hold_stable", 32'(gnt), 32'(stall_gnt));
      stall_q   = gnt_valid && !gnt_ready;
      stall_gnt = gnt;
      if (gnt_valid && gnt_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'(gnt), 32'd0);
        end else begin
          check("sb_gnt", 32'(gnt), 32'(sb_q.pop_front()));
        end
        for (int i = 0; i < N; i++) begin
          if (gnt[i] || !req[i]) wait_cnt[i] = 0;
          else if (!lock) wait_cnt[i]++;
          if (req[i]) check("fair_bound", 32'(wait_cnt[i] < N), 32'd1);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req       = 4'b1111;
    gnt_ready = 1'b0;
    lock      = 1'b0;

    // Reset held two cycles with all requests up
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    @(negedge clk);
    check("rst_gnt2", 32'(gnt), 32'd0);
    check("rst_valid2", 32'(gnt_valid), 32'd0);
    check("rst_idx2", 32'(gnt_idx), 32'd0);

    // Back-to-back rotation, one grant per cycle
    #1;
    rst       = 1'b0;
    gnt_ready = 1'b1;
    push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000); push(4'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rot_valid", 32'(gnt_valid), 32'd1);
    end
    #1 req = '0;
    @(negedge clk);
    check("rot_idle", 32'(gnt_valid), 32'd0);

    // Single pulse request, held grant under backpressure (ptr=1 here)
    #1;
    req       = 4'b0100;
    gnt_ready = 1'b0;
    @(negedge clk);
    check("pulse_gnt", 32'(gnt), 32'b0100);
    check("pulse_idx", 32'(gnt_idx), 32'd2);
    #1 req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sticky_gnt", 32'(gnt), 32'b0100);
    end
    #1;
    gnt_ready = 1'b1;
    push(4'b0100);
    @(negedge clk);
    check("pulse_idle", 32'(gnt_valid), 32'd0);

    // Pointer at 3, wrap to requester 0
    #1;
    req       = 4'b1001;
    gnt_ready = 1'b0;
    @(negedge clk);
    check("wrap_gnt3", 32'(gnt), 32'b1000);
    check("wrap_idx3", 32'(gnt_idx), 32'd3);
    #1;
    gnt_ready = 1'b1;
    push(4'b1000); push(4'b0001);
    @(negedge clk);
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    check("wrap_idx0", 32'(gnt_idx), 32'd0);
    #1 req = '0;
    @(negedge clk);
    check("wrap_idle", 32'(gnt_valid), 32'd0);

    // Reset while a grant is presented with ready high
    #1;
    req       = 4'b0010;
    gnt_ready = 1'b0;
    @(negedge clk);
    check("mid_gnt", 32'(gnt), 32'b0010);
    #1;
    rst       = 1'b1;
    gnt_ready = 1'b1;
    req       = 4'b1111;
    @(negedge clk);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_valid", 32'(gnt_valid), 32'd0);
    check("mid_rst_idx", 32'(gnt_idx), 32'd0);
    #1;
    rst = 1'b0;
    push(4'b0001);
    @(negedge clk);
    check("mid_ptr_zero", 32'(gnt), 32'b0001);
    #1 req = '0;
    @(negedge clk);
    check("mid_idle", 32'(gnt_valid), 32'd0);

    // Lone requester is regranted on every accept
    #1;
    req = 4'b0001;
    push(4'b0001); push(4'b0001); push(4'b0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("solo_gnt", 32'(gnt), 32'b0001);
    end
    #1 req = '0;
    @(negedge clk);
    check("solo_idle", 32'(gnt_valid), 32'd0);

`ifdef RR_ARB_LOCK_EN
    // Move the pointer to 0, then hold requester 0 for three locked accepts
    #1;
    req = 4'b1000;
    push(4'b1000);
    @(negedge clk);
    check("lock_pre", 32'(gnt), 32'b1000);
    #1;
    req = 4'b0011;
    push(4'b0001); push(4'b0001); push(4'b0001); push(4'b0001); push(4'b0010);
    @(negedge clk);
    check("lock_first", 32'(gnt), 32'b0001);
    #1 lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_hold", 32'(gnt), 32'b0001);
    end
    #1 lock = 1'b0;
    @(negedge clk);
    check("lock_release", 32'(gnt), 32'b0010);
    #1 req = '0;
    @(negedge clk);
    check("lock_idle", 32'(gnt_valid), 32'd0);
`endif

    @(negedge clk);
    #3;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
